// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the memory-stage LSU (master) and data memory (slave).
// Request fields stay stable while dmem_req is high; dmem_rdata is valid with dmem_ack.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: IDLE/BUSY/DONE req/ack sequencer with lane steering and load extension.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memtoregM,
    input  logic                 memwriteM,
    input  logic [2:0]           funct3M,
    input  logic [31:0]          aluoutM,
    input  logic [31:0]          writedataM,
    output logic [31:0]          readdataM,
    output logic                 stallM,
    output logic                 bus_errM,
    output logic                 misalignM,
    mem_stage_lsu_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic          is_load_q;

    logic          access;
    logic [1:0]    off;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_ext;

    assign access = memtoregM | memwriteM;
    assign off    = aluoutM[1:0];
    assign stallM = (state == BUSY) || (state == IDLE && access);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = writedataM;
        if (memwriteM) begin
            case (funct3M)
                3'b000: begin
                    be_next    = 4'b0001 << off;
                    wdata_next = {4{writedataM[7:0]}};
                end
                3'b001: begin
                    be_next    = 4'b0011 << {off[1], 1'b0};
                    wdata_next = {2{writedataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Lane selection uses the offset captured at issue, since aluoutM may be stale by ack time.
    always_comb begin
        byte_sel = bus.dmem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = bus.dmem_rdata[15:8];
            2'd2:    byte_sel = bus.dmem_rdata[23:16];
            2'd3:    byte_sel = bus.dmem_rdata[31:24];
            default: ;
        endcase
        half_sel = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus.dmem_rdata;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;
    logic is_half;
    logic is_word;

    always_comb begin
        is_half    = (funct3M == 3'b001) || (memtoregM && !memwriteM && funct3M == 3'b101);
        is_word    = (funct3M == 3'b010);
        misaligned = (is_half && off[0]) || (is_word && off != 2'b00);
    end

    assign misalignM = misalign_q;
`else
    assign misalignM = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            is_load_q      <= 1'b0;
            readdataM      <= 32'd0;
            bus_errM       <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= 32'd0;
            bus.dmem_be    <= 4'd0;
            bus.dmem_wdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            bus_errM <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (access) begin
`ifdef MISALIGN_TRAP_EN
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                            readdataM  <= 32'd0;
                            state      <= DONE;
                        end else
`endif
                        begin
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= memwriteM;
                            bus.dmem_addr  <= {aluoutM[31:2], 2'b00};
                            bus.dmem_be    <= be_next;
                            bus.dmem_wdata <= wdata_next;
                            funct3_q       <= funct3M;
                            off_q          <= off;
                            is_load_q      <= !memwriteM;
                            state          <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (bus.dmem_ack) begin
                        bus.dmem_req <= 1'b0;
                        tmo_cnt      <= '0;
                        if (is_load_q) begin
                            readdataM <= load_ext;
                        end
                        state <= DONE;
                    end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                        bus.dmem_req <= 1'b0;
                        tmo_cnt      <= '0;
                        bus_errM     <= 1'b1;
                        readdataM    <= 32'd0;
                        state        <= DONE;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    bus.dmem_req <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one default instance and one with TIMEOUT_CYCLES=4 sharing stimulus.
// dut1 sees the same ack as dut0 unless block1 masks it for the timeout scenarios.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        memtoregM;
    logic        memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        ack;
    logic [31:0] rdata;
    logic        block1;

    logic [31:0] readdata0, readdata1;
    logic        stall0, stall1;
    logic        bus_err0, bus_err1;
    logic        misalign0, misalign1;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu_if bus0 ();
    mem_stage_lsu_if bus1 ();

    assign bus0.dmem_ack   = ack;
    assign bus0.dmem_rdata = rdata;
    assign bus1.dmem_ack   = ack & ~block1;
    assign bus1.dmem_rdata = rdata;

    mem_stage_lsu dut0 (
        .clk        (clk),
        .reset      (reset),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .funct3M    (funct3M),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdata0),
        .stallM     (stall0),
        .bus_errM   (bus_err0),
        .misalignM  (misalign0),
        .bus        (bus0)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .funct3M    (funct3M),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdata1),
        .stallM     (stall1),
        .bus_errM   (bus_err1),
        .misalignM  (misalign1),
        .bus        (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        memtoregM  = ld;
        memwriteM  = st;
        funct3M    = f3;
        aluoutM    = a;
        writedataM = wd;
        #1;
    endtask

    task automatic bubble();
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    logic [2:0]  ld_f3   [6];
    logic [31:0] ld_addr [6];
    logic [31:0] ld_exp  [6];
    logic [2:0]  st_f3   [5];
    logic [31:0] st_addr [5];
    logic [3:0]  st_be   [5];
    logic [31:0] st_wd   [5];
    int          req_cycles;
    int          stall_cycles;
    logic        early_err;

    initial begin
        ld_f3[0] = 3'b000; ld_addr[0] = 32'h102; ld_exp[0] = 32'hFFFF_FF80;
        ld_f3[1] = 3'b100; ld_addr[1] = 32'h102; ld_exp[1] = 32'h0000_0080;
        ld_f3[2] = 3'b101; ld_addr[2] = 32'h102; ld_exp[2] = 32'h0000_0080;
        ld_f3[3] = 3'b001; ld_addr[3] = 32'h100; ld_exp[3] = 32'hFFFF_FF00;
        ld_f3[4] = 3'b000; ld_addr[4] = 32'h101; ld_exp[4] = 32'hFFFF_FFFF;
        ld_f3[5] = 3'b011; ld_addr[5] = 32'h106; ld_exp[5] = 32'h0080_FF00;

        st_f3[0] = 3'b001; st_addr[0] = 32'h102; st_be[0] = 4'b1100; st_wd[0] = 32'hBEEF_BEEF;
        st_f3[1] = 3'b001; st_addr[1] = 32'h100; st_be[1] = 4'b0011; st_wd[1] = 32'hBEEF_BEEF;
        st_f3[2] = 3'b000; st_addr[2] = 32'h200; st_be[2] = 4'b0001; st_wd[2] = 32'hEFEF_EFEF;
        st_f3[3] = 3'b010; st_addr[3] = 32'h204; st_be[3] = 4'b1111; st_wd[3] = 32'hCAFE_BEEF;
        st_f3[4] = 3'b000; st_addr[4] = 32'h201; st_be[4] = 4'b0010; st_wd[4] = 32'hEFEF_EFEF;

        // Reset with a stale ack already on the bus.
        reset  = 1'b1;
        ack    = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        block1 = 1'b0;
        bubble();
        #1;
        check("rst_req",      bus0.dmem_req,   32'd0);
        check("rst_we",       bus0.dmem_we,    32'd0);
        check("rst_be",       bus0.dmem_be,    32'd0);
        check("rst_addr",     bus0.dmem_addr,  32'd0);
        check("rst_wdata",    bus0.dmem_wdata, 32'd0);
        check("rst_readdata", readdata0,       32'd0);
        check("rst_bus_err",  bus_err0,        32'd0);
        check("rst_misalign", misalign0,       32'd0);
        check("rst_stall",    stall0,          32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("stale_ack_idle_req",   bus0.dmem_req, 32'd0);
        check("stale_ack_idle_stall", stall0,        32'd0);
        check("stale_ack_idle_rd",    readdata0,     32'd0);
        ack = 1'b0;

        // LW 0x100, ack in the third request cycle.
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        check("lw_idle_stall", stall0,        32'd1);
        check("lw_idle_req",   bus0.dmem_req, 32'd0);
        stall_cycles = 1;
        req_cycles   = 0;
        tick();
        check("lw_addr", bus0.dmem_addr, 32'h100);
        check("lw_be",   bus0.dmem_be,   32'hF);
        check("lw_we",   bus0.dmem_we,   32'd0);
        req_cycles   += int'(bus0.dmem_req);
        stall_cycles += int'(stall0);
        tick();
        req_cycles   += int'(bus0.dmem_req);
        stall_cycles += int'(stall0);
        tick();
        req_cycles   += int'(bus0.dmem_req);
        stall_cycles += int'(stall0);
        ack   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick();
        check("lw_req_cycles",   req_cycles,    32'd3);
        check("lw_stall_cycles", stall_cycles,  32'd4);
        check("lw_done_rd",      readdata0,     32'hDEAD_BEEF);
        check("lw_done_stall",   stall0,        32'd0);
        check("lw_done_req",     bus0.dmem_req, 32'd0);
        ack = 1'b0;
        bubble();
        tick();
        check("lw_back_idle_stall", stall0, 32'd0);

        // Back-to-back LW/SW with ack held high, including while IDLE.
        ack   = 1'b1;
        rdata = 32'h1122_3344;
        set_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0);
        check("b2b_lw_idle_stall", stall0,        32'd1);
        check("b2b_lw_idle_req",   bus0.dmem_req, 32'd0);
        tick();
        check("b2b_lw_busy_req",   bus0.dmem_req, 32'd1);
        check("b2b_lw_busy_stall", stall0,        32'd1);
        tick();
        check("b2b_lw_done_stall", stall0,    32'd0);
        check("b2b_lw_done_rd",    readdata0, 32'h1122_3344);
        set_op(1'b0, 1'b1, 3'b010, 32'h108, 32'h1234_5678);
        tick();
        check("b2b_sw_idle_stall", stall0,        32'd1);
        check("b2b_sw_idle_req",   bus0.dmem_req, 32'd0);
        tick();
        check("b2b_sw_req",   bus0.dmem_req,   32'd1);
        check("b2b_sw_we",    bus0.dmem_we,    32'd1);
        check("b2b_sw_be",    bus0.dmem_be,    32'hF);
        check("b2b_sw_addr",  bus0.dmem_addr,  32'h108);
        check("b2b_sw_wdata", bus0.dmem_wdata, 32'h1234_5678);
        tick();
        check("b2b_sw_done_rd",    readdata0, 32'h1122_3344);
        check("b2b_sw_done_stall", stall0,    32'd0);
        ack = 1'b0;
        bubble();
        tick();

        // SB of 0xA5 at 0x203.
        set_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00A5);
        tick();
        check("sb_be",    bus0.dmem_be,    32'h8);
        check("sb_wdata", bus0.dmem_wdata, 32'hA5A5_A5A5);
        check("sb_we",    bus0.dmem_we,    32'd1);
        check("sb_addr",  bus0.dmem_addr,  32'h200);
        ack = 1'b1;
        tick();
        check("sb_rd_held", readdata0, 32'h1122_3344);
        ack = 1'b0;
        bubble();
        tick();

        // Load extension table, rdata 0x0080FF00.
        for (int i = 0; i < 6; i++) begin
            set_op(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'd0);
            tick();
            ack   = 1'b1;
            rdata = 32'h0080_FF00;
            tick();
            check($sformatf("load_ext_%0d", i), readdata0, ld_exp[i]);
            ack = 1'b0;
            bubble();
            tick();
        end

        // Store lane steering table, wd 0xCAFEBEEF.
        for (int i = 0; i < 5; i++) begin
            set_op(1'b0, 1'b1, st_f3[i], st_addr[i], 32'hCAFE_BEEF);
            tick();
            check($sformatf("store_be_%0d", i),    bus0.dmem_be,    32'(st_be[i]));
            check($sformatf("store_wdata_%0d", i), bus0.dmem_wdata, st_wd[i]);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            bubble();
            tick();
        end

        // LW at 0x102.
`ifdef MISALIGN_TRAP_EN
        set_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
        check("mis_idle_stall", stall0, 32'd1);
        tick();
        check("mis_req",      bus0.dmem_req, 32'd0);
        check("mis_pulse",    misalign0,     32'd1);
        check("mis_rd",       readdata0,     32'd0);
        check("mis_stall",    stall0,        32'd0);
        bubble();
        tick();
        check("mis_pulse_end", misalign0, 32'd0);
        rdata = 32'h1357_9BDF;
        set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        bubble();
        tick();
`else
        set_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
        tick();
        check("nomis_pulse", misalign0,      32'd0);
        check("nomis_req",   bus0.dmem_req,  32'd1);
        check("nomis_addr",  bus0.dmem_addr, 32'h100);
        ack   = 1'b1;
        rdata = 32'h1357_9BDF;
        tick();
        check("nomis_rd", readdata0, 32'h1357_9BDF);
        ack = 1'b0;
        bubble();
        tick();
`endif

        // Timeout on dut1 (no ack); dut0 is left waiting in BUSY.
        block1 = 1'b1;
        ack    = 1'b0;
        set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        check("tmo_idle_stall", stall1, 32'd1);
        req_cycles = 0;
        early_err  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            req_cycles += int'(bus1.dmem_req);
            early_err  |= bus_err1;
        end
        tick();
        check("tmo_req_cycles", req_cycles,    32'd4);
        check("tmo_early_err",  early_err,     32'd0);
        check("tmo_bus_err",    bus_err1,      32'd1);
        check("tmo_rd_zero",    readdata1,     32'd0);
        check("tmo_req_drop",   bus1.dmem_req, 32'd0);
        check("tmo_done_stall", stall1,        32'd0);
        bubble();
        tick();
        check("tmo_err_pulse_end", bus_err1, 32'd0);
        check("tmo_idle_again",    stall1,   32'd0);
        check("notmo_still_busy",  bus0.dmem_req, 32'd1);

        // Asynchronous reset while dut0 is in BUSY, then a late ack.
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy_req",   bus0.dmem_req, 32'd0);
        check("rst_busy_stall", stall0,        32'd0);
        check("rst_busy_rd",    readdata0,     32'd0);
        ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("late_ack_req",   bus0.dmem_req, 32'd0);
        check("late_ack_stall", stall0,        32'd0);
        check("late_ack_rd",    readdata0,     32'd0);
        ack = 1'b0;

        // Ack arrives in the cycle the timeout would expire: ack wins.
        block1 = 1'b1;
        rdata  = 32'h0BAD_F00D;
        set_op(1'b1, 1'b0, 3'b010, 32'h310, 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("race_req_still", bus1.dmem_req, 32'd1);
        block1 = 1'b0;
        ack    = 1'b1;
        tick();
        check("race_rd",      readdata1, 32'h0BAD_F00D);
        check("race_no_err",  bus_err1,  32'd0);
        check("race_rd_dut0", readdata0, 32'h0BAD_F00D);
        ack = 1'b0;
        bubble();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
